mem_writeback: RTL and testbench
================================

# mem_writeback

Memory-access and write-back stage that consumes the execute stage's result bundle (ALU result, destination register, store data) and completes it. Loads and stores become a data-memory request/ready transaction. Non-memory results pass straight to the register file. The stage drives the execute stage's `stall_in` while a memory transaction is outstanding, and produces the single register-file write port of the core.

## Interface
Parameters:
- none (XLEN fixed at 32, 5-bit register index)

Ports:
- `req`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ex_valid_in`  in  1  execute bundle valid this cycle
- `ex_opcode_in`  in  7  RV32I opcode of the instruction
- `ex_funct3_in`  in  3  load/store width field
- `ex_result_in`  in  32  ALU result; effective address for loads/stores
- `ex_store_data_in`  in  32  rs2 value for stores
- `ex_rd_in`  in  5  destination register
- `stall_out`  out  1  combinational; drives execute `stall_in`
- `dmem_req_out`  out  1  memory request
- `dmem_we_out`  out  1  1 = store
- `dmem_addr_out`  out  32  word-aligned address (`addr & ~3`)
- `dmem_wdata_out`  out  32  store data, lane-replicated
- `dmem_be_out`  out  4  byte enables
- `dmem_ready_in`  in  1  memory completes the request this cycle
- `dmem_rdata_in`  in  32  load word; valid when `dmem_ready_in` is high
- `wb_rd_write_out`  out  1  register-file write strobe, one-cycle pulse
- `wb_rd_out`  out  5  write index
- `wb_value_out`  out  32  write data
- `misaligned_out`  out  1  one-cycle pulse on misaligned or illegal-width access

## Operation
- States: `IDLE`, `MEM`.
- `IDLE`, `ex_valid_in`=1:
  - **LOAD (0000011) / STORE (0100011), aligned, legal funct3:** latch address, data, funct3, rd, and we. Go to `MEM`.
  - **Misaligned or illegal width:** halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores. Pulse `misaligned_out`. No memory access, no writeback. Stay in `IDLE`.
  - **OP, OP-IMM, LUI, AUIPC, JAL, JALR:** register writeback of `ex_result_in` to `ex_rd_in`.
  - **Other opcodes (BRANCH, FENCE, SYSTEM, unknown):** consumed with no effect.
- `MEM`:
  - `dmem_req_out`=1.
  - All `dmem_*` outputs are held stable until `dmem_ready_in` is sampled high.
  - On ready, a load writes back the extracted value and a store writes nothing. Return to `IDLE`.
- Any writeback with rd=0 is suppressed: `wb_rd_write_out` stays 0.
- Store byte enables, with `a` = `addr[1:0]`:
  - SB: be=`0001<<a`, wdata={4{byte}}
  - SH: be=`0011<<a`, wdata={2{half}}
  - SW: be=`1111`
- Load extraction selects the byte or half lane by `a`:
  - LB / LH sign-extend.
  - LBU / LHU zero-extend.
  - LW passes the word through.
- `stall_out` = (state==`MEM`) | (state==`IDLE` & `ex_valid_in` & aligned memory op).
- `ex_*` inputs are ignored while in `MEM`.

## Timing
- Reset values:
  - state `IDLE`
  - `dmem_req_out`, `dmem_we_out`, `dmem_addr_out`, `dmem_wdata_out`, `dmem_be_out` = 0
  - `wb_rd_write_out`, `wb_rd_out`, `wb_value_out`, `misaligned_out` = 0
- **Non-memory op accepted at edge N:** write pulse during cycle N+1. Back-to-back non-memory ops are accepted every cycle with no bubble.
- **Memory op accepted at edge N:** `dmem_req_out` high from cycle N+1.
  - `dmem_ready_in` is sampled only while `dmem_req_out` is high. Ready at edge N+1 is the minimum latency.
  - Ready at edge M: a load's write pulse occurs in cycle M+1; state is `IDLE` in cycle M+1 and `stall_out` follows the rule above.
- `misaligned_out` is high during cycle N+1 for a bad access accepted at edge N.
- **Reset mid-`MEM`:** the pending access is discarded. `dmem_req_out`=0 and no writeback in the cycle after the reset edge. A late `dmem_ready_in` is ignored.
- **Reset and a valid input in the same edge:** reset wins and the input is dropped.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (`OPC_LOAD`, `OPC_STORE`, `OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`)
  - funct3 width encodings (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`)
  - `mem_wb_state_t` enum
- One sub-module, `load_align`: combinational mapping of {funct3, `addr[1:0]`, rdata} to the extended 32-bit value.
- Store lane logic stays inline.

## Test plan
- ADD result 0x00001234, rd=5 -> one-cycle `wb_rd_write_out`=1, rd=5, value=0x00001234 the next cycle. With rd=0 -> no write.
- SW addr=0x100, data=0xDEADBEEF, ready after 3 cycles:
  - `dmem_req_out` held 3 cycles with addr=0x100, be=1111, we=1, and the payload stable throughout.
  - `stall_out` high throughout; no writeback.
- Loads with rdata=0x80018000:
  - LB addr=0x103 -> 0xFFFFFF80
  - LBU addr=0x103 -> 0x00000080
  - LH addr=0x102 -> 0xFFFF8001
  - LHU addr=0x100 -> 0x00008000
- SB addr=0x101, data=0x000000AB -> be=0010, wdata=0xABABABAB, addr=0x100.
- LW addr=0x102 -> `misaligned_out` pulse, `dmem_req_out` never asserted, no writeback, `stall_out` low.
- Reset asserted during a load wait -> `dmem_req_out`=0 next cycle; a later `dmem_ready_in` yields no writeback; state `IDLE`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and memory/write-back state type.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } mem_wb_state_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half lane out of a load word and extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select then sign/zero extension by load width.
  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    value = {{24{lane_b[7]}}, lane_b};
      F3_BU:   value = {24'h0, lane_b};
      F3_H:    value = {{16{lane_h[15]}}, lane_h};
      F3_HU:   value = {16'h0, lane_h};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_writeback.sv
// Memory-access / write-back stage: runs load/store handshakes with data
// memory, forwards ALU results to the register file, flags bad accesses.
module mem_writeback
  import riscv_pkg::*;
(
  input  logic        req,
  input  logic        rst,
  input  logic        ex_valid_in,
  input  logic [6:0]  ex_opcode_in,
  input  logic [2:0]  ex_funct3_in,
  input  logic [31:0] ex_result_in,
  input  logic [31:0] ex_store_data_in,
  input  logic [4:0]  ex_rd_in,
  output logic        stall_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_be_out,
  input  logic        dmem_ready_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        wb_rd_write_out,
  output logic [4:0]  wb_rd_out,
  output logic [31:0] wb_value_out,
  output logic        misaligned_out
);

  mem_wb_state_t state, state_nxt;

  logic        is_load, is_store, is_mem, is_wb_op;
  logic        width_ok, aligned, mem_ok;
  logic [1:0]  a;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;
  logic [4:0]  rd_q;
  logic [31:0] load_val;

  assign a        = ex_result_in[1:0];
  assign is_load  = (ex_opcode_in == OPC_LOAD);
  assign is_store = (ex_opcode_in == OPC_STORE);
  assign is_mem   = is_load | is_store;
  assign is_wb_op = (ex_opcode_in == OPC_OP)  | (ex_opcode_in == OPC_OP_IMM) |
                    (ex_opcode_in == OPC_LUI) | (ex_opcode_in == OPC_AUIPC)  |
                    (ex_opcode_in == OPC_JAL) | (ex_opcode_in == OPC_JALR);

  // Decode width legality, alignment and store lane placement.
  always_comb begin
    case (ex_funct3_in)
      F3_B, F3_H, F3_W: width_ok = 1'b1;
      F3_BU, F3_HU:     width_ok = is_load;
      default:          width_ok = 1'b0;
    endcase
    case (ex_funct3_in[1:0])
      2'b01:   aligned = ~a[0];
      2'b10:   aligned = (a == 2'b00);
      default: aligned = 1'b1;
    endcase
    case (ex_funct3_in[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << a;
        wdata_nxt = {4{ex_store_data_in[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << a;
        wdata_nxt = {2{ex_store_data_in[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = ex_store_data_in;
      end
    endcase
  end

  assign mem_ok       = is_mem & width_ok & aligned;
  assign stall_out    = (state == MEM) | (ex_valid_in & mem_ok);
  assign dmem_req_out = (state == MEM);

  load_align u_load_align (
    .funct3  (f3_q),
    .addr_lo (a_q),
    .rdata   (dmem_rdata_in),
    .value   (load_val)
  );

  // State register.
  always_ff @(posedge req) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: enter MEM on a good memory op, leave on ready.
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (ex_valid_in && mem_ok) state_nxt = MEM;
    end else if (dmem_ready_in) begin
      state_nxt = IDLE;
    end
  end

  // Request payload latch, write-back and misaligned pulses.
  always_ff @(posedge req) begin
    if (rst) begin
      dmem_we_out     <= 1'b0;
      dmem_addr_out   <= '0;
      dmem_wdata_out  <= '0;
      dmem_be_out     <= '0;
      wb_rd_write_out <= 1'b0;
      wb_rd_out       <= '0;
      wb_value_out    <= '0;
      misaligned_out  <= 1'b0;
      f3_q            <= '0;
      a_q             <= '0;
      rd_q            <= '0;
    end else begin
      wb_rd_write_out <= 1'b0;
      misaligned_out  <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid_in) begin
          if (is_mem) begin
            if (mem_ok) begin
              dmem_addr_out  <= {ex_result_in[31:2], 2'b00};
              dmem_we_out    <= is_store;
              dmem_be_out    <= be_nxt;
              dmem_wdata_out <= is_store ? wdata_nxt : 32'h0;
              f3_q           <= ex_funct3_in;
              a_q            <= a;
              rd_q           <= ex_rd_in;
            end else begin
              misaligned_out <= 1'b1;
            end
          end else if (is_wb_op && ex_rd_in != 5'd0) begin
            wb_rd_write_out <= 1'b1;
            wb_rd_out       <= ex_rd_in;
            wb_value_out    <= ex_result_in;
          end
        end
      end else if (dmem_ready_in && !dmem_we_out && rd_q != 5'd0) begin
        wb_rd_write_out <= 1'b1;
        wb_rd_out       <= rd_q;
        wb_value_out    <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: directed cases plus random ops
// against a transaction-level reference model.
module tb_mem_writeback;

  logic        req = 1'b0;
  logic        rst;
  logic        ex_valid_in;
  logic [6:0]  ex_opcode_in;
  logic [2:0]  ex_funct3_in;
  logic [31:0] ex_result_in, ex_store_data_in;
  logic [4:0]  ex_rd_in;
  logic        stall_out, dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_ready_in;
  logic [31:0] dmem_rdata_in;
  logic        wb_rd_write_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_value_out;
  logic        misaligned_out;

  int n_chk = 0;
  int n_pass = 0;

  mem_writeback dut (
    .req(req), .rst(rst),
    .ex_valid_in(ex_valid_in), .ex_opcode_in(ex_opcode_in),
    .ex_funct3_in(ex_funct3_in), .ex_result_in(ex_result_in),
    .ex_store_data_in(ex_store_data_in), .ex_rd_in(ex_rd_in),
    .stall_out(stall_out), .dmem_req_out(dmem_req_out),
    .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out),
    .dmem_wdata_out(dmem_wdata_out), .dmem_be_out(dmem_be_out),
    .dmem_ready_in(dmem_ready_in), .dmem_rdata_in(dmem_rdata_in),
    .wb_rd_write_out(wb_rd_write_out), .wb_rd_out(wb_rd_out),
    .wb_value_out(wb_value_out), .misaligned_out(misaligned_out)
  );

  always #5 req = ~req;

  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, ADD = 7'h33;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  // Reference model: 0 = no effect, 1 = reg write, 2 = memory op, 3 = bad access.
  function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (op == LOAD) begin
      if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 3;
      return (addr % size == 0) ? 2 : 3;
    end
    if (op == STORE) begin
      if (f3 > 2) return 3;
      return (addr % size == 0) ? 2 : 3;
    end
    if (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17 || op == 7'h6f || op == 7'h67)
      return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> ((addr % 4) * 8);
    case (f3)
      3'd0: begin v = v & 32'hff;   if (v >= 32'h80)   v = v | 32'hffffff00; end
      3'd4: v = v & 32'hff;
      3'd1: begin v = v & 32'hffff; if (v >= 32'h8000) v = v | 32'hffff0000; end
      3'd5: v = v & 32'hffff;
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return 4'(((1 << size) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hff) * 32'h01010101;
    if (f3 == 3'd1) return (d & 32'hffff) * 32'h00010001;
    return d;
  endfunction

  // Issue one op from IDLE and follow it to completion.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input int delay,
                        input logic [31:0] rdata);
    int k;
    k = classify(op, f3, addr);
    @(negedge req);
    ex_valid_in = 1'b1; ex_opcode_in = op; ex_funct3_in = f3;
    ex_result_in = addr; ex_store_data_in = data; ex_rd_in = rd;
    #1 chk("stall_accept", 32'(stall_out), 32'(k == 2));
    @(negedge req);
    ex_valid_in = 1'b0;
    ex_opcode_in = $urandom; ex_result_in = $urandom; ex_rd_in = $urandom;
    #1;
    case (k)
      1: begin
        chk("wb_write", 32'(wb_rd_write_out), 32'(rd != 0));
        if (rd != 0) begin
          chk("wb_rd", 32'(wb_rd_out), 32'(rd));
          chk("wb_value", wb_value_out, addr);
        end
        chk("mis_none", 32'(misaligned_out), 0);
      end
      0: begin
        chk("nop_write", 32'(wb_rd_write_out), 0);
        chk("nop_mis", 32'(misaligned_out), 0);
      end
      3: begin
        chk("mis_pulse", 32'(misaligned_out), 1);
        chk("mis_req", 32'(dmem_req_out), 0);
        chk("mis_write", 32'(wb_rd_write_out), 0);
        chk("mis_stall", 32'(stall_out), 0);
      end
      default: begin
        for (int i = 0; i <= delay; i++) begin
          if (i == delay) begin dmem_ready_in = 1'b1; dmem_rdata_in = rdata; end
          else dmem_rdata_in = $urandom;
          chk("req_held", 32'(dmem_req_out), 1);
          chk("req_addr", dmem_addr_out, addr & ~32'h3);
          chk("req_we", 32'(dmem_we_out), 32'(op == STORE));
          if (op == STORE) begin
            chk("req_be", 32'(dmem_be_out), 32'(ref_be(f3, addr)));
            chk("req_wdata", dmem_wdata_out, ref_wdata(f3, data));
          end
          chk("req_stall", 32'(stall_out), 1);
          chk("req_nowb", 32'(wb_rd_write_out), 0);
          @(negedge req); #1;
        end
        dmem_ready_in = 1'b0;
        chk("done_req", 32'(dmem_req_out), 0);
        chk("done_stall", 32'(stall_out), 0);
        chk("done_write", 32'(wb_rd_write_out), 32'(op == LOAD && rd != 0));
        if (op == LOAD && rd != 0) begin
          chk("load_rd", 32'(wb_rd_out), 32'(rd));
          chk("load_value", wb_value_out, ref_load(f3, addr, rdata));
        end
      end
    endcase
  endtask

  logic [6:0] ops [11] = '{7'h03, 7'h23, 7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h6f, 7'h63, 7'h0f, 7'h73};

  initial begin
    logic [4:0]  prd;
    logic [31:0] pval;
    rst = 1'b1; ex_valid_in = 1'b0; ex_opcode_in = '0; ex_funct3_in = '0;
    ex_result_in = '0; ex_store_data_in = '0; ex_rd_in = '0;
    dmem_ready_in = 1'b0; dmem_rdata_in = '0;
    repeat (2) @(negedge req);
    chk("rst_req", 32'(dmem_req_out), 0);
    chk("rst_we", 32'(dmem_we_out), 0);
    chk("rst_addr", dmem_addr_out, 0);
    chk("rst_wdata", dmem_wdata_out, 0);
    chk("rst_be", 32'(dmem_be_out), 0);
    chk("rst_write", 32'(wb_rd_write_out), 0);
    chk("rst_rd", 32'(wb_rd_out), 0);
    chk("rst_value", wb_value_out, 0);
    chk("rst_mis", 32'(misaligned_out), 0);
    chk("rst_stall", 32'(stall_out), 0);
    rst = 1'b0;

    // Directed cases.
    run_op(ADD, 3'd0, 32'h00001234, 0, 5'd5, 0, 0);
    run_op(ADD, 3'd0, 32'h00001234, 0, 5'd0, 0, 0);
    run_op(STORE, 3'd2, 32'h100, 32'hDEADBEEF, 5'd3, 2, 0);
    run_op(LOAD, 3'd0, 32'h103, 0, 5'd4, 0, 32'h80018000);
    run_op(LOAD, 3'd4, 32'h103, 0, 5'd4, 1, 32'h80018000);
    run_op(LOAD, 3'd1, 32'h102, 0, 5'd6, 0, 32'h80018000);
    run_op(LOAD, 3'd5, 32'h100, 0, 5'd6, 3, 32'h80018000);
    run_op(STORE, 3'd0, 32'h101, 32'h000000AB, 5'd0, 0, 0);
    run_op(LOAD, 3'd2, 32'h102, 0, 5'd9, 0, 0);
    run_op(STORE, 3'd1, 32'h103, 32'h1234, 5'd0, 0, 0);
    run_op(LOAD, 3'd3, 32'h100, 0, 5'd9, 0, 0);

    // Back-to-back register writes, one per cycle.
    prd = 0; pval = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge req);
      #1;
      if (i > 0) begin
        chk("b2b_write", 32'(wb_rd_write_out), 1);
        chk("b2b_rd", 32'(wb_rd_out), 32'(prd));
        chk("b2b_value", wb_value_out, pval);
      end
      prd = 5'($urandom_range(1, 31)); pval = $urandom;
      ex_valid_in = 1'b1; ex_opcode_in = ADD; ex_result_in = pval; ex_rd_in = prd;
    end
    @(negedge req);
    ex_valid_in = 1'b0;
    #1;
    chk("b2b_last", wb_value_out, pval);

    // Reset and valid on the same edge: input dropped.
    @(negedge req);
    rst = 1'b1; ex_valid_in = 1'b1; ex_opcode_in = ADD; ex_result_in = 32'h55; ex_rd_in = 5'd5;
    @(negedge req);
    rst = 1'b0; ex_valid_in = 1'b0;
    #1 chk("rst_drop", 32'(wb_rd_write_out), 0);

    // Reset during a load wait.
    @(negedge req);
    ex_valid_in = 1'b1; ex_opcode_in = LOAD; ex_funct3_in = 3'd2;
    ex_result_in = 32'h200; ex_rd_in = 5'd7;
    @(negedge req);
    ex_valid_in = 1'b0;
    #1 chk("rmem_req", 32'(dmem_req_out), 1);
    rst = 1'b1;
    @(negedge req);
    rst = 1'b0;
    #1 chk("rmem_req_off", 32'(dmem_req_out), 0);
    chk("rmem_nowb", 32'(wb_rd_write_out), 0);
    dmem_ready_in = 1'b1; dmem_rdata_in = 32'hCAFEF00D;
    @(negedge req);
    dmem_ready_in = 1'b0;
    #1 chk("rmem_late", 32'(wb_rd_write_out), 0);
    chk("rmem_stall", 32'(stall_out), 0);
    chk("rmem_idle", 32'(dmem_req_out), 0);

    // Random ops against the model.
    for (int i = 0; i < 120; i++) begin
      logic [31:0] ad;
      ad = $urandom;
      run_op(ops[$urandom_range(0, 10)], 3'($urandom), ad, $urandom,
             5'($urandom), $urandom_range(0, 3), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
